// File: rtl/parity_frame_sched_if.sv
// Bundle of the request/result signals between the parity scheduler and its users.
// The slave modport is the scheduler; the master modport is the requester/consumer side.
interface parity_frame_sched_if #(
    parameter int DW = 16
);
    logic [1:0]    req_valid;
    logic [DW-1:0] req0_data;
    logic [DW-1:0] req1_data;
    logic [1:0]    req_ready;
    logic          res_valid;
    logic          res_ready;
    logic          res_parity;
    logic          res_id;
    logic          busy;

    modport slave (
        input  req_valid, req0_data, req1_data, res_ready,
        output req_ready, res_valid, res_parity, res_id, busy
    );

    modport master (
        output req_valid, req0_data, req1_data, res_ready,
        input  req_ready, res_valid, res_parity, res_id, busy
    );
endinterface

// File: rtl/parity_frame_sched.sv
// Round-robin frame scheduler for a shared XOR-reduction parity unit, one tagged result per frame.
// Defining PARITY_FRAME_ODD_EN switches the result to odd parity (inverted XOR, resets to 1).
module parity_frame_sched #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    parity_frame_sched_if.slave bus
);

`ifdef PARITY_FRAME_ODD_EN
    localparam logic PAR_INV = 1'b1;
`else
    localparam logic PAR_INV = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t         state;
    logic           acc;
    logic [CNT_W-1:0] cnt;
    logic           gid;
    logic           last_gnt;
    logic [1:0]     req_ready_q;
    logic           res_valid_q;
    logic           res_parity_q;
    logic           res_id_q;
    logic           busy_q;

    logic [DW-1:0]  beat_data;
    logic           beat_par;
    logic           beat;
    logic           pick;

    assign beat_data = gid ? bus.req1_data : bus.req0_data;
    assign beat_par  = ^beat_data;
    assign beat      = bus.req_valid[gid] & req_ready_q[gid];

    // On a tie the requester that did not own the previous frame wins.
    assign pick = (&bus.req_valid) ? ~last_gnt : bus.req_valid[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= 1'b0;
            cnt          <= '0;
            gid          <= 1'b0;
            last_gnt     <= 1'b1;
            req_ready_q  <= 2'b00;
            res_valid_q  <= 1'b0;
            res_parity_q <= PAR_INV;
            res_id_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        gid         <= pick;
                        acc         <= 1'b0;
                        cnt         <= '0;
                        req_ready_q <= pick ? 2'b10 : 2'b01;
                        busy_q      <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= acc ^ beat_par;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_BEAT) begin
                            res_parity_q <= PAR_INV ^ acc ^ beat_par;
                            res_id_q     <= gid;
                            res_valid_q  <= 1'b1;
                            req_ready_q  <= 2'b00;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        last_gnt    <= gid;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_parity = res_parity_q;
    assign bus.res_id     = res_id_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_sched.sv
// Directed bench for parity_frame_sched: frame-level reference model checked every cycle,
// plus literal expectations for the single-frame, contention, backpressure, bubble and reset cases.
module tb_parity_frame_sched;
    localparam int DW        = 16;
    localparam int FRAME_LEN = 4;

`ifdef PARITY_FRAME_ODD_EN
    localparam logic PINV = 1'b1;
`else
    localparam logic PINV = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    parity_frame_sched_if #(.DW(DW)) bus ();

    parity_frame_sched #(
        .DW(DW),
        .FRAME_LEN(FRAME_LEN),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Frame-level model: who owns the unit, which words it has taken, and the pending result.
    bit            mInit = 1'b0;
    int            mOwner;
    bit            mLast;
    bit            mResValid;
    bit            mResPar;
    bit            mResId;
    logic [DW-1:0] mWords[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            mInit     = 1'b1;
            mOwner    = -1;
            mLast     = 1'b1;
            mResValid = 1'b0;
            mResPar   = PINV;
            mResId    = 1'b0;
            mWords.delete();
        end else if (mInit) begin
            if (mResValid) begin
                if (bus.res_ready) begin
                    mResValid = 1'b0;
                    mLast     = mResId;
                end
            end else if (mOwner < 0) begin
                if (bus.req_valid == 2'b11)
                    mOwner = mLast ? 0 : 1;
                else if (bus.req_valid != 2'b00)
                    mOwner = bus.req_valid[1] ? 1 : 0;
                mWords.delete();
            end else if (bus.req_valid[mOwner]) begin
                int ones;
                mWords.push_back(mOwner == 1 ? bus.req1_data : bus.req0_data);
                if (mWords.size() == FRAME_LEN) begin
                    ones = 0;
                    foreach (mWords[i]) ones += $countones(mWords[i]);
                    mResPar   = PINV ^ ones[0];
                    mResId    = (mOwner == 1);
                    mResValid = 1'b1;
                    mOwner    = -1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mInit) begin
            checkOutput("cyc_req_ready", bus.req_ready,
                        mOwner < 0 ? 32'd0 : (mOwner == 1 ? 32'd2 : 32'd1));
            checkOutput("cyc_ready_onehot", bus.req_ready == 2'b11, 0);
            checkOutput("cyc_res_valid", bus.res_valid, mResValid);
            checkOutput("cyc_busy", bus.busy, (mOwner >= 0) || mResValid);
            if (mResValid) begin
                checkOutput("cyc_res_parity", bus.res_parity, mResPar);
                checkOutput("cyc_res_id", bus.res_id, mResId);
            end
        end
    end

    // Completed handshakes, in order, for the ordering checks.
    logic [1:0] obs[$];
    always @(posedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready)
            obs.push_back({bus.res_id, bus.res_parity});
    end

    task automatic applyStimulus(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                                 input logic rr);
        bus.req_valid = v;
        bus.req0_data = d0;
        bus.req1_data = d1;
        bus.res_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic waitResult(input string name, input logic [1:0] v, input logic [15:0] d,
                              input logic rr);
        for (int c = 0; c < 20; c++) begin
            if (bus.res_valid) break;
            applyStimulus(v, d, d, rr);
        end
        checkOutput(name, bus.res_valid, 1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);
        applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        int pattern[7];
        pattern = '{1, 0, 0, 1, 1, 0, 1};

        bus.req_valid = 2'b00;
        bus.req0_data = '0;
        bus.req1_data = '0;
        bus.res_ready = 1'b1;

        doReset();
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_res_valid", bus.res_valid, 0);
        checkOutput("rst_req_ready", bus.req_ready, 0);
        checkOutput("rst_res_id", bus.res_id, 0);
        checkOutput("rst_res_parity", bus.res_parity, PINV);

        // Single frame: 1+2+0+16 ones -> even parity 1, result five edges after valid.
        applyStimulus(2'b01, 16'h0001, 16'h0, 1'b1);
        checkOutput("s1_grant_ready", bus.req_ready, 2'b01);
        applyStimulus(2'b01, 16'h0001, 16'h0, 1'b1);
        applyStimulus(2'b01, 16'h0003, 16'h0, 1'b1);
        applyStimulus(2'b01, 16'h0000, 16'h0, 1'b1);
        checkOutput("s1_not_yet", bus.res_valid, 0);
        applyStimulus(2'b01, 16'hFFFF, 16'h0, 1'b1);
        checkOutput("s1_res_valid", bus.res_valid, 1);
        checkOutput("s1_res_parity", bus.res_parity, 1'b1 ^ PINV);
        checkOutput("s1_res_id", bus.res_id, 0);
        applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);
        checkOutput("s1_released", bus.res_valid, 0);

        // Contention from a fresh reset: grants alternate 0,1,0,1, four ones per frame.
        doReset();
        obs.delete();
        for (int c = 0; c < 60 && obs.size() < 4; c++)
            applyStimulus(2'b11, 16'h0001, 16'h0001, 1'b1);
        applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);
        checkOutput("s2_count", obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            checkOutput("s2_id", obs[i][1], i % 2);
            checkOutput("s2_parity", obs[i][0], PINV);
        end

        // Backpressure: requester 1 owned the last frame, so requester 0 wins; 12 ones -> 0.
        waitResult("s3_res_valid", 2'b11, 16'h0007, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(2'b11, 16'h0007, 16'h0007, 1'b0);
            checkOutput("s3_hold_valid", bus.res_valid, 1);
            checkOutput("s3_hold_parity", bus.res_parity, PINV);
            checkOutput("s3_hold_id", bus.res_id, 0);
            checkOutput("s3_hold_ready", bus.req_ready, 0);
        end
        applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);
        checkOutput("s3_released", bus.res_valid, 0);

        // Bubbles on requester 1: only the four valid cycles count, four ones -> 0.
        applyStimulus(2'b10, 16'h0, 16'h8000, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) checkOutput("s4_not_yet", bus.res_valid, 0);
            applyStimulus(pattern[i] != 0 ? 2'b10 : 2'b00, 16'h0, 16'h8000, 1'b1);
        end
        checkOutput("s4_res_valid", bus.res_valid, 1);
        checkOutput("s4_res_parity", bus.res_parity, PINV);
        checkOutput("s4_res_id", bus.res_id, 1);
        applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);

        // Reset after two beats drops the frame; a fresh requester-1 frame has 11 ones -> 1.
        applyStimulus(2'b01, 16'h00F0, 16'h0, 1'b1);
        applyStimulus(2'b01, 16'h00F0, 16'h0, 1'b1);
        applyStimulus(2'b01, 16'h00F0, 16'h0, 1'b1);
        rst_n = 1'b0;
        applyStimulus(2'b01, 16'h00F0, 16'h0, 1'b1);
        checkOutput("s5_rst_busy", bus.busy, 0);
        checkOutput("s5_rst_res_valid", bus.res_valid, 0);
        checkOutput("s5_rst_ready", bus.req_ready, 0);
        rst_n = 1'b1;
        applyStimulus(2'b10, 16'h0, 16'h0003, 1'b1);
        applyStimulus(2'b10, 16'h0, 16'h0003, 1'b1);
        applyStimulus(2'b10, 16'h0, 16'h0001, 1'b1);
        applyStimulus(2'b10, 16'h0, 16'h0000, 1'b1);
        applyStimulus(2'b10, 16'h0, 16'h00FF, 1'b1);
        checkOutput("s5_res_valid", bus.res_valid, 1);
        checkOutput("s5_res_parity", bus.res_parity, 1'b1 ^ PINV);
        checkOutput("s5_res_id", bus.res_id, 1);
        applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);
        applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
